// File: rtl/scalable_mux_pkg.sv
// Shared constants for the scalable_mux leaf cell.
package scalable_mux_pkg;

  // Legal data-width range of one mux instance.
  localparam int unsigned MUX_SIZE_MIN = 1;
  localparam int unsigned MUX_SIZE_MAX = 64;

  // Value each output bit takes while the optional register is in reset.
  localparam logic MUX_RST_BIT = 1'b0;

endpackage : scalable_mux_pkg

// File: rtl/scalable_mux_bit.sv
// One-bit 2:1 select cell.
// The conditional operator gives the wanted unknown-select behaviour:
// an X/Z select yields the input value when both inputs agree and X
// otherwise. Synthesis reduces it to an ordinary 2:1 mux.
module scalable_mux_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  // Select b when i_sel is high, a when low, bitwise X-merge when unknown.
  assign o_y = i_sel ? i_b : i_a;

endmodule : scalable_mux_bit

// File: rtl/scalable_mux.sv
// Width-parameterized 2:1 multiplexer with an optional output register.
// Every bit is an independent scalable_mux_bit cell; no bit depends on
// any other, and no truncation or extension happens inside the block.
module scalable_mux
  import scalable_mux_pkg::*;
#(
  parameter int unsigned SIZE    = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            sel,
  output logic [SIZE-1:0] out
);

  logic [SIZE-1:0] w_mux;

  // Replicate the one-bit select cell across the data width.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_bit
    scalable_mux_bit u_bit (
      .i_a   (a[gi]),
      .i_b   (b[gi]),
      .i_sel (sel),
      .o_y   (w_mux[gi])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [SIZE-1:0] r_out;

    // Load the selected data every cycle; reset clears it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out <= {SIZE{MUX_RST_BIT}};
      end else begin
        r_out <= w_mux;
      end
    end

    assign out = r_out;
  end else begin : g_comb
    // clk and rst_n play no part in the combinational variant.
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = clk & rst_n;
    assign out              = w_mux;
  end

endmodule : scalable_mux

// File: tb/tb_scalable_mux.sv
// Directed bench for scalable_mux: four registered instances (6/4/3/1 bits,
// narrower ones fed from the LSBs) and one combinational 6-bit instance.
module tb_scalable_mux;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [5:0] a;
  logic [5:0] b;
  logic       sel;
  logic [5:0] out6;
  logic [3:0] out4;
  logic [2:0] out3;
  logic [0:0] out1;
  logic [5:0] outc;

  int checks;
  int failures;
  bit four_state;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic       sel;
    logic [5:0] exp;
    bit         x_only;
  } vec_t;

  vec_t vecs[11];

  scalable_mux #(.SIZE(6), .REG_OUT(1'b1)) u_m6 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .out(out6));
  scalable_mux #(.SIZE(4), .REG_OUT(1'b1)) u_m4 (
    .clk(clk), .rst_n(rst_n), .a(a[3:0]), .b(b[3:0]), .sel(sel), .out(out4));
  scalable_mux #(.SIZE(3), .REG_OUT(1'b1)) u_m3 (
    .clk(clk), .rst_n(rst_n), .a(a[2:0]), .b(b[2:0]), .sel(sel), .out(out3));
  scalable_mux #(.SIZE(1), .REG_OUT(1'b1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .a(a[0:0]), .b(b[0:0]), .sel(sel), .out(out1));
  scalable_mux #(.SIZE(6), .REG_OUT(1'b0)) u_c6 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .out(outc));

  always #5 clk = clk_en ? ~clk : clk;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_reg_all(input string tag, input logic [5:0] exp);
    chk({tag, "_out6"}, out6, exp);
    chk({tag, "_out4"}, {2'b00, out4}, {2'b00, exp[3:0]});
    chk({tag, "_out3"}, {3'b000, out3}, {3'b000, exp[2:0]});
    chk({tag, "_out1"}, {5'b00000, out1}, {5'b00000, exp[0:0]});
  endtask

  initial begin
    logic probe;
    checks     = 0;
    failures   = 0;
    probe      = 1'bx;
    four_state = $isunknown(probe);

    vecs[0]  = '{6'b010001, 6'b101110, 1'b1, 6'b101110, 1'b0};
    vecs[1]  = '{6'b010001, 6'b101110, 1'b0, 6'b010001, 1'b0};
    vecs[2]  = '{6'b010001, 6'b101110, 1'bx, 6'bxxxxxx, 1'b1};
    vecs[3]  = '{6'b111011, 6'b111011, 1'bx, 6'b111011, 1'b0};
    vecs[4]  = '{6'b111011, 6'b111011, 1'b1, 6'b111011, 1'b0};
    vecs[5]  = '{6'b111011, 6'b111011, 1'b0, 6'b111011, 1'b0};
    vecs[6]  = '{6'b010001, 6'b111011, 1'bx, 6'bx1x0x1, 1'b1};
    vecs[7]  = '{6'b010001, 6'b111011, 1'b1, 6'b111011, 1'b0};
    vecs[8]  = '{6'b010001, 6'b111011, 1'b0, 6'b010001, 1'b0};
    vecs[9]  = '{6'b111111, 6'b000000, 1'b0, 6'b111111, 1'b0};
    vecs[10] = '{6'b111111, 6'b000000, 1'b1, 6'b000000, 1'b0};

    clk    = 1'b0;
    clk_en = 1'b1;
    rst_n  = 1'b0;
    a      = 6'b101010;
    b      = 6'b010101;
    sel    = 1'b0;

    // Reset state: registered outputs zero, combinational output live.
    #2;
    chk_reg_all("reset", 6'b000000);
    chk("reset_comb", outc, 6'b101010);
    @(posedge clk);
    #1;
    chk("reset_hold_out6", out6, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      if (!vecs[i].x_only || four_state) begin
        @(negedge clk);
        a   = vecs[i].a;
        b   = vecs[i].b;
        sel = vecs[i].sel;
        #1;
        chk($sformatf("v%0d_comb", i), outc, vecs[i].exp);
        @(posedge clk);
        #1;
        chk_reg_all($sformatf("v%0d", i), vecs[i].exp);
      end
    end

    // One-cycle latency: a change at the negedge is not yet visible.
    @(negedge clk);
    a   = 6'b000111;
    b   = 6'b110000;
    sel = 1'b1;
    #1;
    chk("latency_before_edge", out6, 6'b000000);
    @(posedge clk);
    #1;
    chk("latency_after_edge", out6, 6'b110000);

    // Asynchronous reset mid-cycle, then release and first load.
    @(negedge clk);
    a   = 6'b111111;
    sel = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_out6", out6, 6'b111111);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reg_all("async_reset", 6'b000000);
    chk("async_reset_comb", outc, 6'b111111);
    @(posedge clk);
    #1;
    chk("reset_held_out6", out6, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after_release_out6", out6, 6'b000000);
    @(posedge clk);
    #1;
    chk_reg_all("first_load", 6'b111111);

    // Combinational variant with the clock stopped.
    @(negedge clk);
    clk_en = 1'b0;
    a      = 6'b100110;
    b      = 6'b011001;
    sel    = 1'b0;
    #3;
    chk("noclk_sel0", outc, 6'b100110);
    sel = 1'b1;
    #3;
    chk("noclk_sel1", outc, 6'b011001);
    rst_n = 1'b0;
    #3;
    chk("noclk_rst_low", outc, 6'b011001);
    sel = 1'b0;
    #3;
    chk("noclk_rst_low_sel0", outc, 6'b100110);
    rst_n = 1'b1;
    #3;
    chk("noclk_rst_high", outc, 6'b100110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scalable_mux
